// File: rtl/sound_scheduler.sv
// sound_scheduler: tick-paced melody sequencer and fixed-priority SFX arbiter for a single buzzer.
// Optional SFX_QUEUE_EN keeps lower-priority requests pending while a higher SFX plays.
`default_nettype none

module sound_scheduler #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_play_en,
    input  logic       i_land,
    input  logic       i_score,
    input  logic       i_game_over,
    output logic [5:0] o_music_scale,
    output logic       o_sfx_active,
    output logic       o_halted,
    output logic [3:0] o_melody_idx
);

    localparam int             TICK_DIV    = CLK_HZ / TICK_HZ;
    localparam int             CW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  c_tick_max  = CW'(TICK_DIV - 1);
    localparam logic [1:0]     c_sel_land  = 2'd0;
    localparam logic [1:0]     c_sel_score = 2'd1;
    localparam logic [1:0]     c_sel_over  = 2'd2;

    typedef enum logic [1:0] {
        ST_MELODY = 2'd0,
        ST_SFX    = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    function automatic logic [5:0] f_rom(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd14:  f_rom = 6'd8;
            4'd2, 4'd3, 4'd6:   f_rom = 6'd12;
            4'd4, 4'd5:         f_rom = 6'd13;
            4'd8, 4'd9:         f_rom = 6'd11;
            4'd10, 4'd11:       f_rom = 6'd10;
            4'd12, 4'd13:       f_rom = 6'd9;
            default:            f_rom = 6'd0;
        endcase
    endfunction

    function automatic logic [5:0] f_sfx_code(input logic [1:0] sel, input logic [2:0] step);
        f_sfx_code = 6'd0;
        case (sel)
            c_sel_land:  f_sfx_code = 6'd1;
            c_sel_score: begin
                case (step[1:0])
                    2'd0:    f_sfx_code = 6'd8;
                    2'd1:    f_sfx_code = 6'd10;
                    2'd2:    f_sfx_code = 6'd12;
                    default: f_sfx_code = 6'd15;
                endcase
            end
            default: begin
                case (step[2:1])
                    2'd0:    f_sfx_code = 6'd12;
                    2'd1:    f_sfx_code = 6'd10;
                    2'd2:    f_sfx_code = 6'd8;
                    default: f_sfx_code = 6'd1;
                endcase
            end
        endcase
    endfunction

    function automatic logic [2:0] f_sfx_last(input logic [1:0] sel);
        case (sel)
            c_sel_land:  f_sfx_last = 3'd1;
            c_sel_score: f_sfx_last = 3'd3;
            default:     f_sfx_last = 3'd7;
        endcase
    endfunction

    logic [CW-1:0] r_cnt;
    logic          w_tick;
    state_t        r_state, w_state_nx;
    logic [1:0]    r_sel, w_sel_nx;
    logic [2:0]    r_step, w_step_nx;
    logic [2:0]    r_pend;
    logic [2:0]    w_set, w_clr;
    logic [5:0]    r_scale, w_scale_nx;
    logic          r_act, w_act_nx;
    logic          r_halted, w_halted_nx;
    logic [3:0]    r_idx, w_idx_nx;
    logic          w_any;
    logic [1:0]    w_hi_sel;
    logic          w_do_start, w_do_melody;

    assign w_tick   = (r_cnt == c_tick_max);
    assign w_any    = |r_pend;
    assign w_hi_sel = r_pend[2] ? c_sel_over : (r_pend[1] ? c_sel_score : c_sel_land);

    // Land/score requests are not accepted while halted after game over.
    assign w_set = {i_game_over,
                    i_score & (r_state != ST_HALT),
                    i_land  & (r_state != ST_HALT)};

    always_comb begin
        w_state_nx  = r_state;
        w_sel_nx    = r_sel;
        w_step_nx   = r_step;
        w_scale_nx  = r_scale;
        w_act_nx    = r_act;
        w_halted_nx = r_halted;
        w_idx_nx    = r_idx;
        w_clr       = 3'b000;
        w_do_start  = 1'b0;
        w_do_melody = 1'b0;
        if (w_tick) begin
            case (r_state)
                ST_MELODY: begin
                    if (w_any) w_do_start  = 1'b1;
                    else       w_do_melody = 1'b1;
                end
                ST_SFX: begin
                    if (w_any && (w_hi_sel >= r_sel)) begin
                        w_do_start = 1'b1;
                    end else if (r_step == f_sfx_last(r_sel)) begin
                        if (w_any) begin
                            w_do_start = 1'b1;
                        end else if (r_sel == c_sel_over) begin
                            w_state_nx  = ST_HALT;
                            w_scale_nx  = 6'd0;
                            w_act_nx    = 1'b0;
                            w_halted_nx = 1'b1;
                        end else begin
                            w_do_melody = 1'b1;
                        end
                    end else begin
                        w_step_nx  = 3'(r_step + 3'd1);
                        w_scale_nx = f_sfx_code(r_sel, 3'(r_step + 3'd1));
                    end
                end
                ST_HALT: begin
                    if (!i_play_en) begin
                        w_do_melody = 1'b1;
`ifndef SFX_QUEUE_EN
                        w_clr = 3'b111;
`endif
                    end else if (r_pend[2]) begin
                        w_do_start = 1'b1;
                    end
                end
                default: w_state_nx = ST_MELODY;
            endcase

            if (w_do_start) begin
                w_state_nx  = ST_SFX;
                w_sel_nx    = w_hi_sel;
                w_step_nx   = 3'd0;
                w_scale_nx  = f_sfx_code(w_hi_sel, 3'd0);
                w_act_nx    = 1'b1;
                w_halted_nx = 1'b0;
`ifdef SFX_QUEUE_EN
                w_clr = 3'b001 << w_hi_sel;
`else
                // Starting a sound drops every request of equal or lower priority.
                case (w_hi_sel)
                    c_sel_land:  w_clr = 3'b001;
                    c_sel_score: w_clr = 3'b011;
                    default:     w_clr = 3'b111;
                endcase
`endif
            end

            if (w_do_melody) begin
                w_state_nx  = ST_MELODY;
                w_act_nx    = 1'b0;
                w_halted_nx = 1'b0;
                if (i_play_en) begin
                    w_scale_nx = f_rom(r_idx);
                    w_idx_nx   = 4'(r_idx + 4'd1);
                end else begin
                    w_scale_nx = 6'd0;
                    w_idx_nx   = 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_state  <= ST_MELODY;
            r_sel    <= c_sel_land;
            r_step   <= 3'd0;
            r_pend   <= 3'b000;
            r_scale  <= 6'd0;
            r_act    <= 1'b0;
            r_halted <= 1'b0;
            r_idx    <= 4'd0;
        end else begin
            r_cnt    <= w_tick ? '0 : CW'(r_cnt + 1'b1);
            r_state  <= w_state_nx;
            r_sel    <= w_sel_nx;
            r_step   <= w_step_nx;
            // A pulse landing on the clearing edge wins, so it is serviced at the next tick.
            r_pend   <= (r_pend & ~w_clr) | w_set;
            r_scale  <= w_scale_nx;
            r_act    <= w_act_nx;
            r_halted <= w_halted_nx;
            r_idx    <= w_idx_nx;
        end
    end

    assign o_music_scale = r_scale;
    assign o_sfx_active  = r_act;
    assign o_halted      = r_halted;
    assign o_melody_idx  = r_idx;

endmodule

`default_nettype wire

// File: tb/tb_sound_scheduler.sv
// tb_sound_scheduler: directed checks of melody sequencing, SFX priority, halt and reset behaviour.
`default_nettype none

module tb_sound_scheduler;

    localparam int CLK_HZ    = 80;
    localparam int TICK_HZ   = 8;
    localparam int TICK_LAST = CLK_HZ / TICK_HZ - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       play_en = 1'b0;
    logic       land = 1'b0;
    logic       score = 1'b0;
    logic       game_over = 1'b0;
    logic [5:0] scale;
    logic       sfx_act;
    logic       halted;
    logic [3:0] idx;

    int errors = 0;
    int checks = 0;
    int tb_ph;
    int rom [16] = '{8, 8, 12, 12, 13, 13, 12, 0, 11, 11, 10, 10, 9, 9, 8, 0};
    int score_seq [4] = '{8, 10, 12, 15};
    int over_seq [8] = '{12, 12, 10, 10, 8, 8, 1, 1};

    sound_scheduler #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_play_en    (play_en),
        .i_land       (land),
        .i_score      (score),
        .i_game_over  (game_over),
        .o_music_scale(scale),
        .o_sfx_active (sfx_act),
        .o_halted     (halted),
        .o_melody_idx (idx)
    );

    always #5 clk = ~clk;

    // Independent phase of the tick divider, used only to locate tick edges.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ph <= 0;
        else        tb_ph <= (tb_ph == TICK_LAST) ? 0 : tb_ph + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while (tb_ph != TICK_LAST && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check_val("tick_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic tick_exp(input string tag, input int s, input int a, input int i, input int h);
        wait_tick();
        check_val({tag, "_scale"}, 32'(scale), 32'(s));
        check_val({tag, "_act"}, 32'(sfx_act), 32'(a));
        check_val({tag, "_idx"}, 32'(idx), 32'(i));
        check_val({tag, "_halt"}, 32'(halted), 32'(h));
    endtask

    task automatic pulse(input logic [2:0] v);
        @(negedge clk);
        {game_over, score, land} = v;
        @(negedge clk);
        {game_over, score, land} = 3'b000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        play_en = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_scale", 32'(scale), 0);
        check_val("rst_act", 32'(sfx_act), 0);
        check_val("rst_halt", 32'(halted), 0);
        check_val("rst_idx", 32'(idx), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 17; k++) tick_exp("t1_mel", rom[k % 16], 0, (k + 1) % 16, 0);

        for (int k = 1; k < 5; k++) tick_exp("t2_mel", rom[k], 0, k + 1, 0);
        pulse(3'b010);
        for (int k = 0; k < 4; k++) tick_exp("t2_score", score_seq[k], 1, 5, 0);
        tick_exp("t2_resume", 13, 0, 6, 0);

        pulse(3'b011);
        for (int k = 0; k < 4; k++) tick_exp("t3_score", score_seq[k], 1, 6, 0);
`ifdef SFX_QUEUE_EN
        tick_exp("t3_land0", 1, 1, 6, 0);
        tick_exp("t3_land1", 1, 1, 6, 0);
`endif
        tick_exp("t3_resume", 12, 0, 7, 0);

        pulse(3'b001);
        tick_exp("t4_land", 1, 1, 7, 0);
        pulse(3'b100);
        for (int k = 0; k < 8; k++) tick_exp("t4_over", over_seq[k], 1, 7, 0);
        tick_exp("t4_halt", 0, 0, 7, 1);
        pulse(3'b010);
        tick_exp("t4_halt_ign", 0, 0, 7, 1);
        @(negedge clk);
        play_en = 1'b0;
        tick_exp("t4_unhalt", 0, 0, 0, 0);
        @(negedge clk);
        play_en = 1'b1;
        tick_exp("t4_mel", 8, 0, 1, 0);

        pulse(3'b010);
        tick_exp("t5_s0", 8, 1, 1, 0);
        tick_exp("t5_s1", 10, 1, 1, 0);
        tick_exp("t5_s2", 12, 1, 1, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_scale", 32'(scale), 0);
        check_val("t5_rst_act", 32'(sfx_act), 0);
        check_val("t5_rst_idx", 32'(idx), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick_exp("t5_restart", 8, 0, 1, 0);

        begin
            int n = 0;
            @(negedge clk);
            while (tb_ph != TICK_LAST && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) check_val("t6_tick_timeout", 0, 1);
        end
        land = 1'b1;
        @(posedge clk);
        #1;
        check_val("t6_ontick_scale", 32'(scale), 8);
        check_val("t6_ontick_act", 32'(sfx_act), 0);
        check_val("t6_ontick_idx", 32'(idx), 2);
        @(negedge clk);
        land = 1'b0;
        tick_exp("t6_land0", 1, 1, 2, 0);
        tick_exp("t6_land1", 1, 1, 2, 0);
        tick_exp("t6_resume", 12, 0, 3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
